// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and types for the mac arbiter slice.
//   MAC_AW / MAC_CW / MAC_ZW : default operand, addend and result widths
//   MODE_CT1 / MODE_CT2      : bit positions of the mode controls in reqN_mode
//   tag_t                    : in-flight tag {valid, chan}
package mac_pkg;

  localparam int unsigned MAC_AW = 16;
  localparam int unsigned MAC_CW = 32;
  localparam int unsigned MAC_ZW = MAC_CW + 1;

  localparam int unsigned MODE_CT1 = 0;
  localparam int unsigned MODE_CT2 = 1;

  typedef struct packed {
    logic valid;
    logic chan;
  } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe: fixed-depth shift register of in-flight tags.
//   clk         : rising-edge clock
//   i_clr       : synchronous clear of every stage (active-high)
//   i_tag       : tag entering stage 0 (valid=0 on cycles with no issue)
//   o_tag       : tag leaving the last stage
//   o_any_valid : at least one stage holds a valid tag
module mac_tag_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic i_clr,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_valid
);

  tag_t r_tags [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tags[i] <= '0;
      end
    end else begin
      r_tags[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
    end
  end

  assign o_tag = r_tags[DEPTH-1];

  always_comb begin
    o_any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_any_valid = o_any_valid | r_tags[i].valid;
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: shares one fixed-latency mac between two request channels.
//   clk, rst                 : clock and synchronous active-high reset
//   reqN_valid/ready         : channel N request handshake (ready is combinational)
//   reqN_a/b/c/mode/last     : channel N payload; last=0 holds the burst lock
//   mac_a/b/c/ct1/ct2        : registered operands to the mac, held between issues
//   mac_z                    : mac result, valid MAC_LAT cycles after issue
//   rspN_valid/z             : channel N result pulse and held result value
//   busy                     : an operation is in flight or a burst lock is held
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned AW      = MAC_AW,
  parameter int unsigned CW      = MAC_CW,
  parameter int unsigned ZW      = MAC_ZW,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_a,
  input  logic [AW-1:0] req0_b,
  input  logic [CW-1:0] req0_c,
  input  logic [1:0]    req0_mode,
  input  logic          req0_last,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_a,
  input  logic [AW-1:0] req1_b,
  input  logic [CW-1:0] req1_c,
  input  logic [1:0]    req1_mode,
  input  logic          req1_last,

  output logic [AW-1:0] mac_a,
  output logic [AW-1:0] mac_b,
  output logic [CW-1:0] mac_c,
  output logic          mac_ct1,
  output logic          mac_ct2,
  input  logic [ZW-1:0] mac_z,

  output logic          rsp0_valid,
  output logic [ZW-1:0] rsp0_z,
  output logic          rsp1_valid,
  output logic [ZW-1:0] rsp1_z,

  output logic          busy
);

  // One stage per mac latency cycle plus the issue register stage.
  localparam int unsigned TAG_DEPTH = MAC_LAT + 1;

  logic          r_rr;         // 0: channel 0 preferred on contention
  logic          r_lock;
  logic          r_lock_chan;
  logic [AW-1:0] r_mac_a;
  logic [AW-1:0] r_mac_b;
  logic [CW-1:0] r_mac_c;
  logic          r_mac_ct1;
  logic          r_mac_ct2;
  logic          r_rsp0_valid;
  logic          r_rsp1_valid;
  logic [ZW-1:0] r_rsp0_z;
  logic [ZW-1:0] r_rsp1_z;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_acc;
  logic          w_acc_chan;
  logic          w_acc_last;
  logic [AW-1:0] w_acc_a;
  logic [AW-1:0] w_acc_b;
  logic [CW-1:0] w_acc_c;
  logic [1:0]    w_acc_mode;
  tag_t          w_tag_in;
  tag_t          w_tag_out;
  logic          w_tags_busy;

  // Grant: lock restricts to the locked channel; otherwise single valid wins,
  // and the RR pointer breaks ties. Nothing is granted while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (r_lock) begin
        w_gnt0 = req0_valid && !r_lock_chan;
        w_gnt1 = req1_valid && r_lock_chan;
      end else if (req0_valid && (!req1_valid || !r_rr)) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign w_acc      = w_gnt0 | w_gnt1;
  assign w_acc_chan = w_gnt1;
  assign w_acc_last = w_gnt1 ? req1_last : req0_last;
  assign w_acc_a    = w_gnt1 ? req1_a    : req0_a;
  assign w_acc_b    = w_gnt1 ? req1_b    : req0_b;
  assign w_acc_c    = w_gnt1 ? req1_c    : req0_c;
  assign w_acc_mode = w_gnt1 ? req1_mode : req0_mode;

  // Arbitration state and issue registers; mac_* hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_chan <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_c     <= '0;
      r_mac_ct1   <= 1'b0;
      r_mac_ct2   <= 1'b0;
    end else if (w_acc) begin
      r_rr        <= ~w_acc_chan;
      r_lock      <= ~w_acc_last;
      r_lock_chan <= w_acc_chan;
      r_mac_a     <= w_acc_a;
      r_mac_b     <= w_acc_b;
      r_mac_c     <= w_acc_c;
      r_mac_ct1   <= w_acc_mode[MODE_CT1];
      r_mac_ct2   <= w_acc_mode[MODE_CT2];
    end
  end

  assign mac_a   = r_mac_a;
  assign mac_b   = r_mac_b;
  assign mac_c   = r_mac_c;
  assign mac_ct1 = r_mac_ct1;
  assign mac_ct2 = r_mac_ct2;

  assign w_tag_in.valid = w_acc;
  assign w_tag_in.chan  = w_acc_chan;

  mac_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk         (clk),
    .i_clr       (rst),
    .i_tag       (w_tag_in),
    .o_tag       (w_tag_out),
    .o_any_valid (w_tags_busy)
  );

  // The exiting tag lines up with mac_z for the op it was pushed with.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_z     <= '0;
      r_rsp1_z     <= '0;
    end else begin
      r_rsp0_valid <= w_tag_out.valid && !w_tag_out.chan;
      r_rsp1_valid <= w_tag_out.valid && w_tag_out.chan;
      if (w_tag_out.valid && !w_tag_out.chan) begin
        r_rsp0_z <= mac_z;
      end
      if (w_tag_out.valid && w_tag_out.chan) begin
        r_rsp1_z <= mac_z;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_z     = r_rsp0_z;
  assign rsp1_z     = r_rsp1_z;

  assign busy = w_tags_busy | r_lock;

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

  typedef struct {
    logic [32:0] z;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Default-latency DUT signals
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] req0_c = '0, req1_c = '0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic        req0_last = 1'b0, req1_last = 1'b0;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_c;
  logic        mac_ct1, mac_ct2;
  logic [32:0] mac_z = '0;
  logic        rsp0_valid, rsp1_valid, busy;
  logic [32:0] rsp0_z, rsp1_z;

  // MAC_LAT=3 DUT signals (channel 1 unused)
  logic        d3_valid = 1'b0;
  logic        d3_ready, d3_ready1;
  logic [15:0] d3_a = '0, d3_b = '0;
  logic [31:0] d3_c = '0;
  logic [15:0] d3_mac_a, d3_mac_b;
  logic [31:0] d3_mac_c;
  logic        d3_ct1, d3_ct2;
  logic [32:0] d3_pipe [3];
  logic        d3_rsp0_valid, d3_rsp1_valid, d3_busy;
  logic [32:0] d3_rsp0_z, d3_rsp1_z;

  exp_t q0[$], q1[$], q3[$];
  int   gnt_log[$];
  logic chk_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference mac behaviour used by both the mac models and the scoreboard.
  function automatic logic [32:0] mac_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [31:0] c, input logic [1:0] mode);
    logic [32:0] p;
    logic [32:0] z;
    p = {17'b0, a} * {17'b0, b};
    z = mode[0] ? (p + {1'b0, c}) : (p - {1'b0, c});
    if (mode[1]) z = ~z;
    return z;
  endfunction

  always @(posedge clk) mac_z <= mac_f(mac_a, mac_b, mac_c, {mac_ct2, mac_ct1});
  always @(posedge clk) begin
    d3_pipe[0] <= mac_f(d3_mac_a, d3_mac_b, d3_mac_c, {d3_ct2, d3_ct1});
    d3_pipe[1] <= d3_pipe[0];
    d3_pipe[2] <= d3_pipe[1];
  end

  mac_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req0_mode  (req0_mode),
    .req0_last  (req0_last),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .req1_mode  (req1_mode),
    .req1_last  (req1_last),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_c      (mac_c),
    .mac_ct1    (mac_ct1),
    .mac_ct2    (mac_ct2),
    .mac_z      (mac_z),
    .rsp0_valid (rsp0_valid),
    .rsp0_z     (rsp0_z),
    .rsp1_valid (rsp1_valid),
    .rsp1_z     (rsp1_z),
    .busy       (busy)
  );

  mac_arbiter #(
    .MAC_LAT (3)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (d3_valid),
    .req0_ready (d3_ready),
    .req0_a     (d3_a),
    .req0_b     (d3_b),
    .req0_c     (d3_c),
    .req0_mode  (2'b01),
    .req0_last  (1'b1),
    .req1_valid (1'b0),
    .req1_ready (d3_ready1),
    .req1_a     (16'h0),
    .req1_b     (16'h0),
    .req1_c     (32'h0),
    .req1_mode  (2'b00),
    .req1_last  (1'b1),
    .mac_a      (d3_mac_a),
    .mac_b      (d3_mac_b),
    .mac_c      (d3_mac_c),
    .mac_ct1    (d3_ct1),
    .mac_ct2    (d3_ct2),
    .mac_z      (d3_pipe[2]),
    .rsp0_valid (d3_rsp0_valid),
    .rsp0_z     (d3_rsp0_z),
    .rsp1_valid (d3_rsp1_valid),
    .rsp1_z     (d3_rsp1_z),
    .busy       (d3_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, inout exp_t q[$], input logic [32:0] z);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected response: got z=%0h expected none (cycle %0d)", name, z, cyc);
    end else begin
      e = q.pop_front();
      chk({name, " z"}, 64'(z), 64'(e.z));
      chk({name, " cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  // Monitor first, then record accepts as issued stimulus with expected results.
  always @(negedge clk) begin
    if (rsp0_valid) pop_chk("rsp0", q0, rsp0_z);
    if (rsp1_valid) pop_chk("rsp1", q1, rsp1_z);
    if (d3_rsp0_valid) pop_chk("lat3 rsp0", q3, d3_rsp0_z);
    if (d3_rsp1_valid) pop_chk("lat3 rsp1", q3, d3_rsp1_z);
    if (chk_busy) chk("busy in burst", 64'(busy), 64'd1);
    if (rst) begin
      q0.delete();
      q1.delete();
      q3.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        q0.push_back('{mac_f(req0_a, req0_b, req0_c, req0_mode), cyc + 3});
        gnt_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back('{mac_f(req1_a, req1_b, req1_c, req1_mode), cyc + 3});
        gnt_log.push_back(1);
      end
      if (d3_valid && d3_ready) q3.push_back('{mac_f(d3_a, d3_b, d3_c, 2'b01), cyc + 5});
    end
  end

  task automatic send(input int ch, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] c, input logic [1:0] mode, input logic last);
    int n;
    if (ch == 0) begin
      req0_a = a; req0_b = b; req0_c = c; req0_mode = mode; req0_last = last;
      req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_c = c; req1_mode = mode; req1_last = last;
      req1_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(ch == 0 ? req0_ready : req1_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready timeout ch%0d: got no ready expected ready within 50 cycles", ch);
    end
    @(posedge clk);
    #1;
    if (ch == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // pat bit i holds the channel expected for the i-th grant.
  task automatic chk_gnt(input string name, input int n, input logic [15:0] pat);
    chk({name, " grant count"}, 64'(gnt_log.size()), 64'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++) begin
      chk($sformatf("%s grant %0d", name, i), 64'(gnt_log[i]), 64'(pat[i]));
    end
    gnt_log.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q3.size() != 0 || busy || d3_busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle timeout: got pending work expected idle within 100 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset mac_a/b/c", {mac_a, mac_b, mac_c}, 64'd0);
    chk("reset mac_ct", {mac_ct2, mac_ct1}, 64'd0);
    chk("reset rsp valid", {rsp1_valid, rsp0_valid}, 64'd0);
    chk("reset rsp0_z", 64'(rsp0_z), 64'd0);
    chk("reset rsp1_z", 64'(rsp1_z), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Single ch0 request
    send(0, 16'h0457, 16'h7BA8, 32'hAAAAAAAA, 2'b01, 1'b1);
    chk("single mac_ct1", 64'(mac_ct1), 64'd1);
    chk("single mac_ct2", 64'(mac_ct2), 64'd0);
    chk("single mac_a", 64'(mac_a), 64'h0457);
    chk("single mac_b", 64'(mac_b), 64'h7BA8);
    chk("single mac_c", 64'(mac_c), 64'hAAAAAAAA);
    wait_idle();
    chk("idle hold mac_a", 64'(mac_a), 64'h0457);
    chk_gnt("single", 1, 16'b0);

    // Single ch1 request, mode bits swapped; leaves the RR pointer at ch0
    send(1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 2'b10, 1'b1);
    chk("ch1 mac_ct", {mac_ct2, mac_ct1}, 64'b10);
    wait_idle();
    chk_gnt("single ch1", 1, 16'b1);

    // Contention: both channels valid continuously, expect strict alternation
    fork
      for (int i = 0; i < 3; i++) send(0, 16'(i + 1), 16'h0100, 32'(i), 2'b01, 1'b1);
      for (int i = 0; i < 3; i++) send(1, 16'(i + 9), 16'h0011, 32'(i * 7), 2'b00, 1'b1);
    join
    wait_idle();
    chk_gnt("contention", 6, 16'b101010);

    // Burst lock: ch1 burst of 4 while ch0 waits
    fork
      begin
        send(1, 16'h1111, 16'h0002, 32'h10, 2'b01, 1'b0);
        chk_busy = 1'b1;
        send(1, 16'h2222, 16'h0003, 32'h20, 2'b01, 1'b0);
        send(1, 16'h3333, 16'h0004, 32'h30, 2'b01, 1'b0);
        send(1, 16'h4444, 16'h0005, 32'h40, 2'b01, 1'b1);
      end
      begin
        @(posedge clk);
        #1;
        send(0, 16'h5555, 16'h0006, 32'h50, 2'b11, 1'b1);
        chk_busy = 1'b0;
      end
    join
    wait_idle();
    chk_gnt("burst", 5, 16'b01111);

    // Locked stall: ch0 holds the lock with valid low, ch1 must wait
    send(0, 16'h0AAA, 16'h0BBB, 32'hCCC, 2'b01, 1'b0);
    fork
      send(1, 16'h0DDD, 16'h0EEE, 32'hFFF, 2'b00, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("locked stall req1_ready", 64'(req1_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0, 16'h0123, 16'h0456, 32'h789, 2'b01, 1'b1);
      end
    join
    wait_idle();
    chk_gnt("locked stall", 3, 16'b100);

    // Reset mid-flight: two locked ops then reset; their responses must vanish
    send(0, 16'h7777, 16'h0007, 32'h7, 2'b01, 1'b0);
    send(0, 16'h8888, 16'h0008, 32'h8, 2'b01, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post-reset busy", 64'(busy), 64'd0);
    chk("post-reset rsp valid", {rsp1_valid, rsp0_valid}, 64'd0);
    gnt_log.delete();
    // A ch1 grant here shows the ch0 lock was dropped
    send(1, 16'h9999, 16'h0009, 32'h9, 2'b01, 1'b1);
    wait_idle();
    chk_gnt("after reset", 1, 16'b1);

    // MAC_LAT=3 instance: 8 back-to-back issues
    d3_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d3_a = 16'(16'h0100 + i);
      d3_b = 16'(3 * i + 1);
      d3_c = 32'(i * 32'h1000);
      @(negedge clk);
      chk($sformatf("lat3 ready %0d", i), 64'(d3_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    d3_valid = 1'b0;
    wait_idle();

    chk("final q0 empty", 64'(q0.size()), 64'd0);
    chk("final q1 empty", 64'(q1.size()), 64'd0);
    chk("final q3 empty", 64'(q3.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
